// File: rtl/flog_stream_ctrl.sv
// flog_stream_ctrl: valid/ready streaming front-end for the bfloat16 log2 core.
// Special operands (zero, denormal, inf, NaN, negative) are resolved locally;
// normal operands are sequenced through the core's reset/valid handshake.
// All results leave in order through a DEPTH-entry result FIFO.
// Build option: define FLOG_TIMEOUT_EN to enable the CORE_RUN watchdog.
module flog_stream_ctrl #(
    parameter int EXP_WIDTH   = 8,
    parameter int FRACT_WIDTH = 7,
    parameter int DEPTH       = 4,
    parameter int RST_CYCLES  = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_sign,
    input  logic [EXP_WIDTH-1:0]   in_exp,
    input  logic [FRACT_WIDTH-1:0] in_fract,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   core_rst,
    output logic                   core_sign,
    output logic [EXP_WIDTH-1:0]   core_exp,
    output logic [FRACT_WIDTH-1:0] core_fract,
    output logic                   core_valid_i,
    input  logic                   core_s,
    input  logic [EXP_WIDTH-1:0]   core_e,
    input  logic [FRACT_WIDTH-1:0] core_f,
    input  logic                   core_valid_o,
    output logic                   out_sign,
    output logic [EXP_WIDTH-1:0]   out_exp,
    output logic [FRACT_WIDTH-1:0] out_fract,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   err_timeout
);

    localparam int DW    = 1 + EXP_WIDTH + FRACT_WIDTH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RST_W = $clog2(RST_CYCLES + 1);

    localparam logic [EXP_WIDTH-1:0]   EXP_ONES  = '1;
    localparam logic [FRACT_WIDTH-1:0] FRACT_MSB = FRACT_WIDTH'(1) << (FRACT_WIDTH - 1);
    localparam logic [DW-1:0] QNAN    = {1'b0, EXP_ONES, FRACT_MSB};
    localparam logic [DW-1:0] POS_INF = {1'b0, EXP_ONES, {FRACT_WIDTH{1'b0}}};
    localparam logic [DW-1:0] NEG_INF = {1'b1, EXP_ONES, {FRACT_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, CORE_RST, CORE_RUN, CORE_DONE} state_t;

    state_t                 state_q, state_d;
    logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
    logic                   core_sign_q, core_sign_d;
    logic [EXP_WIDTH-1:0]   core_exp_q, core_exp_d;
    logic [FRACT_WIDTH-1:0] core_fract_q, core_fract_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [DW-1:0]          mem_q [DEPTH];

    logic                   push_en;
    logic [DW-1:0]          push_data;
    logic                   fifo_pop;
    logic [DW:0]            cls;
    logic                   in_accept;
    logic                   tmo_hit;

    // Returns {is_special, special_result}; ordering matters: any NaN first,
    // then +inf, then zero/denormal of either sign, then remaining negatives.
    function automatic logic [DW:0] classify(input logic                   s,
                                             input logic [EXP_WIDTH-1:0]   e,
                                             input logic [FRACT_WIDTH-1:0] f);
        logic [DW:0] r;
        r = {1'b0, s, e, f};
        if (e == EXP_ONES) begin
            if (f != '0)   r = {1'b1, QNAN};
            else if (!s)   r = {1'b1, POS_INF};
            else           r = {1'b1, QNAN};
        end else if (e == '0) begin
            r = {1'b1, NEG_INF};
        end else if (s) begin
            r = {1'b1, QNAN};
        end
        return r;
    endfunction

`ifdef FLOG_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;

    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

    // Watchdog: counts cycles spent in CORE_RUN; the error flag is sticky.
    always_comb begin
        tmo_cnt_d = '0;
        err_d     = err_q;
        if (state_q == CORE_RUN) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            if (!core_valid_o && tmo_hit) err_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    // Watchdog compiled out: the limit has no effect on this build.
    localparam int timeout_unused = TIMEOUT;
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign in_ready  = !rst && (state_q == IDLE) && (count_q < CNT_W'(DEPTH));
    assign in_accept = in_valid && in_ready;
    assign out_valid = (count_q != '0);
    assign fifo_pop  = out_valid && out_ready;

    assign core_sign  = core_sign_q;
    assign core_exp   = core_exp_q;
    assign core_fract = core_fract_q;

    assign {out_sign, out_exp, out_fract} = out_valid ? mem_q[rd_ptr_q] : '0;

    // Next-state, core handshake outputs and FIFO push selection.
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        core_sign_d  = core_sign_q;
        core_exp_d   = core_exp_q;
        core_fract_d = core_fract_q;
        push_en      = 1'b0;
        push_data    = '0;
        core_rst     = 1'b1;
        core_valid_i = 1'b0;
        cls          = classify(in_sign, in_exp, in_fract);
        case (state_q)
            IDLE: begin
                if (in_accept) begin
                    if (cls[DW]) begin
                        push_en   = 1'b1;
                        push_data = cls[DW-1:0];
                    end else begin
                        core_sign_d  = in_sign;
                        core_exp_d   = in_exp;
                        core_fract_d = in_fract;
                        rst_cnt_d    = '0;
                        state_d      = CORE_RST;
                    end
                end
            end
            CORE_RST: begin
                if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) state_d = CORE_RUN;
                else rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
            CORE_RUN: begin
                core_rst     = 1'b0;
                core_valid_i = 1'b1;
                if (core_valid_o) begin
                    push_en   = 1'b1;
                    push_data = {core_s, core_e, core_f};
                    state_d   = CORE_DONE;
                end else if (tmo_hit) begin
                    push_en   = 1'b1;
                    push_data = QNAN;
                    state_d   = CORE_DONE;
                end
            end
            CORE_DONE: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // FIFO pointer and occupancy update; push and pop together hold count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (fifo_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_en, fifo_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rst_cnt_q    <= '0;
            core_sign_q  <= 1'b0;
            core_exp_q   <= '0;
            core_fract_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            core_sign_q  <= core_sign_d;
            core_exp_q   <= core_exp_d;
            core_fract_q <= core_fract_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage; unreset because the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: tb/tb_flog_stream_ctrl.sv
// Testbench for flog_stream_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model (result queue plus a
// timeline of the operation in flight). A stub core answers with a fixed
// operand-dependent value after a chosen latency.
module tb_flog_stream_ctrl;
    localparam int EXP_WIDTH   = 8;
    localparam int FRACT_WIDTH = 7;
    localparam int DEPTH       = 4;
    localparam int RST_CYCLES  = 2;
    localparam int TIMEOUT     = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_word = 16'h0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        core_valid_o = 1'b0;
    logic [15:0] core_res = 16'h0;

    logic        in_sign;
    logic [7:0]  in_exp;
    logic [6:0]  in_fract;
    logic        in_ready, core_rst, core_sign, core_valid_i;
    logic [7:0]  core_exp;
    logic [6:0]  core_fract;
    logic        core_s;
    logic [7:0]  core_e;
    logic [6:0]  core_f;
    logic        out_sign, out_valid, err_timeout;
    logic [7:0]  out_exp;
    logic [6:0]  out_fract;

    assign {in_sign, in_exp, in_fract} = in_word;
    assign {core_s, core_e, core_f}    = core_res;

    flog_stream_ctrl #(
        .EXP_WIDTH(EXP_WIDTH), .FRACT_WIDTH(FRACT_WIDTH), .DEPTH(DEPTH),
        .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_sign(in_sign), .in_exp(in_exp), .in_fract(in_fract),
        .in_valid(in_valid), .in_ready(in_ready),
        .core_rst(core_rst), .core_sign(core_sign), .core_exp(core_exp),
        .core_fract(core_fract), .core_valid_i(core_valid_i),
        .core_s(core_s), .core_e(core_e), .core_f(core_f), .core_valid_o(core_valid_o),
        .out_sign(out_sign), .out_exp(out_exp), .out_fract(out_fract),
        .out_valid(out_valid), .out_ready(out_ready), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [15:0] m_q[$];
    logic [15:0] popped[$];
    bit          m_busy = 0;
    bit          m_ret = 0;
    bit          m_err = 0;
    int          m_k = 0;
    int          m_lat = 0;
    logic [15:0] m_op = 16'h0;
    bit          last_acc = 0;
    int          force_lat = -1;
    bit          spur_en = 0;
    bit          rand_rst_en = 0;
    bit          rand_or_en = 0;
    int          vi_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // bfloat16 log2 special-operand rules.
    function automatic bit special_result(input logic [15:0] w, output logic [15:0] r);
        logic [7:0] e;
        logic [6:0] f;
        e = w[14:7];
        f = w[6:0];
        r = 16'h0;
        if (e == 8'hFF && f != 7'h0) r = 16'h7FC0;
        else if (w == 16'h7F80)      r = 16'h7F80;
        else if (e == 8'h00)         r = 16'hFF80;
        else if (w[15])              r = 16'h7FC0;
        else                         return 1'b0;
        return 1'b1;
    endfunction

    // Stub core answer: true log2 values for two pinned operands, otherwise
    // an arbitrary operand-dependent pattern.
    function automatic logic [15:0] core_fn(input logic [15:0] w);
        case (w)
            16'h3FFA: return 16'h3F77;
            16'h4000: return 16'h3F80;
            default:  return {w[0], w[15:1] ^ 15'h2B5D};
        endcase
    endfunction

    function automatic bit exp_run();
        return m_busy && !m_ret && (m_k > RST_CYCLES);
    endfunction

    function automatic bit exp_in_ready();
        return !rst && !m_busy && (m_q.size() < DEPTH);
    endfunction

    task automatic drive_core();
        if (exp_run() && (m_k - RST_CYCLES - 1) == m_lat) begin
            core_valid_o = 1'b1;
            core_res     = core_fn(m_op);
        end else begin
            core_valid_o = !exp_run() && spur_en && ($urandom_range(0, 4) == 0);
            core_res     = 16'($urandom);
        end
    endtask

    task automatic compare();
        chk("in_ready", in_ready, exp_in_ready());
        chk("core_rst", core_rst, !exp_run());
        chk("core_valid_i", core_valid_i, exp_run());
        chk("core_operand", {core_sign, core_exp, core_fract}, m_op);
        chk("out_valid", out_valid, m_q.size() > 0);
        chk("out_data", {out_sign, out_exp, out_fract}, (m_q.size() > 0) ? m_q[0] : 16'h0);
        chk("err_timeout", err_timeout, m_err);
        if (core_valid_i) vi_seen++;
        if (!rst && out_valid && out_ready) popped.push_back({out_sign, out_exp, out_fract});
    endtask

    task automatic advance();
        logic [15:0] r;
        bit run, acc;
        run = exp_run();
        acc = in_valid && exp_in_ready();
        last_acc = acc;
        if (rst) begin
            m_q.delete();
            m_busy = 0; m_ret = 0; m_err = 0; m_k = 0; m_op = 16'h0;
        end else begin
            if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (acc) begin
                if (special_result(in_word, r)) m_q.push_back(r);
                else begin
                    m_busy = 1; m_ret = 0; m_k = 0; m_op = in_word;
                    m_lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 6));
                end
            end else if (m_busy && m_ret) begin
                m_busy = 0;
            end else if (run) begin
                if (core_valid_o) begin
                    m_q.push_back(core_fn(m_op));
                    m_ret = 1;
                end
`ifdef FLOG_TIMEOUT_EN
                else if (m_k - RST_CYCLES - 1 == TIMEOUT - 1) begin
                    m_q.push_back(16'h7FC0);
                    m_ret = 1;
                    m_err = 1;
                end
`endif
            end
            if (m_busy) m_k++;
        end
    endtask

    // One clock: inputs set at the falling edge, outputs compared just after.
    task automatic cycle();
        if (rand_rst_en) rst = ($urandom_range(0, 299) == 0);
        if (rand_or_en) out_ready = ($urandom_range(0, 3) != 0);
        drive_core();
        #1;
        compare();
        @(posedge clk);
        advance();
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] w, input int max_wait, output int waited);
        in_word  = w;
        in_valid = 1'b1;
        waited   = 0;
        cycle();
        while (!last_acc && waited < max_wait) begin
            waited++;
            cycle();
        end
        chk("accept_within_bound", last_acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < maxc && (m_busy || m_q.size() > 0); i++) cycle();
        chk("drain_within_bound", m_busy || m_q.size() > 0, 1'b0);
    endtask

    function automatic logic [31:0] pop_at(input int idx);
        return (popped.size() > idx) ? {16'h0, popped[idx]} : 32'hFFFF_FFFF;
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1, "bench time limit");
    end

    initial begin
        int w8;
        int vi0;
        int n;
        logic [15:0] sp[6];
        logic [15:0] w;
        sp = '{16'h7F80, 16'hFF80, 16'h0000, 16'h8000, 16'h7FC1, 16'h0042};

        // Reset state
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_core_rst", core_rst, 1'b1);
        chk("rst_core_valid_i", core_valid_i, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", {out_sign, out_exp, out_fract}, 16'h0);
        chk("rst_core_operand", {core_sign, core_exp, core_fract}, 16'h0);
        chk("rst_err", err_timeout, 1'b0);
        cycle();
        rst = 1'b0;
        cycle();

        // +inf bypass, one-cycle latency, core untouched
        out_ready = 1'b1;
        vi0 = vi_seen;
        send(16'h7F80, 5, w8);
        #1;
        chk("t1_out_valid", out_valid, 1'b1);
        chk("t1_out", {out_sign, out_exp, out_fract}, 16'h7F80);
        drain(10);
        chk("t1_core_idle", vi_seen - vi0, 0);

        // zero/denormal -> -inf, back to back
        popped.delete();
        send(16'h0000, 5, w8); chk("t2_b2b_0", w8, 0);
        send(16'h8000, 5, w8); chk("t2_b2b_1", w8, 0);
        send(16'h0005, 5, w8); chk("t2_b2b_2", w8, 0);
        drain(10);
        chk("t2_n", popped.size(), 3);
        for (int i = 0; i < 3; i++) chk("t2_out", pop_at(i), 16'hFF80);

        // NaNs and negatives -> QNaN
        popped.delete();
        send(16'h7FC0, 5, w8);
        send(16'h7FBF, 5, w8);
        send(16'hD550, 5, w8);
        send(16'hFF80, 5, w8);
        drain(10);
        chk("t3_n", popped.size(), 4);
        for (int i = 0; i < 4; i++) chk("t3_out", pop_at(i), 16'h7FC0);

        // Normal operand through the core
        popped.delete();
        force_lat = 3;
        send(16'h3FFA, 5, w8);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (core_valid_i) break;
            if (core_rst) n++;
            cycle();
        end
        chk("t4_rst_cycles", n, RST_CYCLES);
        drain(40);
        chk("t4_out", pop_at(0), 16'h3F77);

        // Backpressure: fill FIFO with mixed traffic, then release
        popped.delete();
        out_ready = 1'b0;
        force_lat = 2;
        send(16'h7F80, 60, w8);
        send(16'h3FFA, 60, w8);
        send(16'h0000, 60, w8);
        send(16'h4000, 60, w8);
        for (int i = 0; i < 60 && m_busy; i++) cycle();
        #1;
        chk("t5_in_ready_full", in_ready, 1'b0);
        chk("t5_out_valid", out_valid, 1'b1);
        drain(40);
        chk("t5_out0", pop_at(0), 16'h7F80);
        chk("t5_out1", pop_at(1), 16'h3F77);
        chk("t5_out2", pop_at(2), 16'hFF80);
        chk("t5_out3", pop_at(3), 16'h3F80);

        // Reset during CORE_RUN with two queued results
        out_ready = 1'b0;
        force_lat = 40;
        send(16'h7F80, 10, w8);
        send(16'h0000, 10, w8);
        send(16'h3FFA, 10, w8);
        for (int i = 0; i < 10 && !exp_run(); i++) cycle();
        cycle();
        #1;
        chk("t6_running", core_valid_i, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_core_rst", core_rst, 1'b1);
        chk("t6_core_valid_i", core_valid_i, 1'b0);
        spur_en = 1'b1;
        repeat (10) cycle();
        spur_en = 1'b0;

`ifdef FLOG_TIMEOUT_EN
        // Core that never answers
        popped.delete();
        force_lat = 100000;
        send(16'h3FFA, 5, w8);
        drain(TIMEOUT + 20);
        chk("tmo_out", pop_at(0), 16'h7FC0);
        #1;
        chk("tmo_err", err_timeout, 1'b1);
`endif

        // Randomized traffic with backpressure, spurious core pulses, resets
        force_lat   = -1;
        spur_en     = 1'b1;
        rand_or_en  = 1'b1;
        rand_rst_en = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            case ($urandom_range(0, 3))
                0, 1:    w = {1'b0, 8'($urandom_range(1, 254)), 7'($urandom)};
                2:       w = 16'($urandom);
                default: w = sp[$urandom_range(0, 5)];
            endcase
            in_valid = 1'b0;
            in_word  = 16'($urandom);
            repeat ($urandom_range(0, 2)) cycle();
            send(w, 300, w8);
        end
        rand_rst_en = 1'b0;
        rand_or_en  = 1'b0;
        rst = 1'b0;
        drain(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
